// File: rtl/mcu_pkg.sv
// Shared types and select encoding for the MCU frame scheduler and the MCU
// interface input mux.
package mcu_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    LOAD      = 2'b01,
    WAIT_DONE = 2'b10
  } state_t;

  localparam logic [1:0] SEL_ROLL  = 2'b00;
  localparam logic [1:0] SEL_PITCH = 2'b01;
  localparam logic [1:0] SEL_YAW   = 2'b10;

  localparam int ANG_W   = 16;
  localparam int FRAME_W = 3 * ANG_W;

endpackage

// File: rtl/mcu_frame_buf.sv
// Active/pending angle frame storage. The active frame stays frozen while the
// scheduler sends it; one newer frame may wait in pending, and losing an
// unconsumed pending frame raises the sticky overrun flag.
module mcu_frame_buf
  import mcu_pkg::*;
(
  input  logic               clk,
  input  logic               n_rst,
  input  logic               capture,
  input  logic               frame_valid,
  input  logic               clear_err,
  input  logic [FRAME_W-1:0] frame_in,
  output logic [FRAME_W-1:0] active_out,
  output logic               pend_valid_out,
  output logic               overrun_out
);

  logic [FRAME_W-1:0] active_q;
  logic [FRAME_W-1:0] pend_q;
  logic               pend_valid_q;
  logic               overrun_q;
  logic               consume;
  logic               load_direct;
  logic               pend_wr;
  logic               overrun_set;

  // A capture takes pending first; an incoming frame not taken directly goes to pending.
  always_comb begin
    consume     = capture & pend_valid_q;
    load_direct = capture & ~pend_valid_q;
    pend_wr     = frame_valid & ~load_direct;
    overrun_set = pend_wr & pend_valid_q & ~consume;
  end

  // Frame registers, pending flag and sticky overrun (a new event beats clear).
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      active_q     <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      if (consume)          active_q <= pend_q;
      else if (load_direct) active_q <= frame_in;

      if (pend_wr)      pend_q <= frame_in;

      if (pend_wr)      pend_valid_q <= 1'b1;
      else if (consume) pend_valid_q <= 1'b0;

      if (overrun_set)    overrun_q <= 1'b1;
      else if (clear_err) overrun_q <= 1'b0;
    end
  end

  assign active_out     = active_q;
  assign pend_valid_out = pend_valid_q;
  assign overrun_out    = overrun_q;

endmodule

// File: rtl/mcu_frame_sched.sv
// Sends roll, pitch and yaw of each accepted frame to the MCU SPI slave
// interface one channel at a time, waiting for done (or a timeout) between
// channels.
//
// state     | meaning
// IDLE      | no frame in flight; capture pending or incoming frame when configured
// LOAD      | one-cycle write_enable pulse for channel sel
// WAIT_DONE | waiting for done_in or timeout, then next channel or back to IDLE
module mcu_frame_sched
  import mcu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TIMEOUT_W      = 16,
  parameter int FCNT_W         = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              angles_valid_in,
  input  logic [15:0]       roll_in,
  input  logic [15:0]       pitch_in,
  input  logic [15:0]       yaw_in,
  input  logic              configured_in,
  input  logic              done_in,
  input  logic              clear_err_in,
  output logic              write_enable_out,
  output logic [1:0]        output_select_out,
  output logic [15:0]       roll_out,
  output logic [15:0]       pitch_out,
  output logic [15:0]       yaw_out,
  output logic              busy_out,
  output logic              overrun_out,
  output logic              timeout_out,
  output logic [FCNT_W-1:0] frame_count_out
);

  state_t                state_q, state_d;
  logic [1:0]            sel_q, sel_d;
  logic [TIMEOUT_W-1:0]  tcnt_q, tcnt_d;
  logic [FCNT_W-1:0]     fcnt_q, fcnt_d;
  logic                  timeout_q;
  logic                  timeout_set;
  logic                  capture;
  logic                  pend_valid;
  logic                  tmo_hit;
  logic [FRAME_W-1:0]    active;

  assign capture = (state_q == IDLE) && configured_in && (pend_valid || angles_valid_in);
  assign tmo_hit = (tcnt_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

  mcu_frame_buf u_frame_buf (
    .clk            (clk),
    .n_rst          (n_rst),
    .capture        (capture),
    .frame_valid    (angles_valid_in),
    .clear_err      (clear_err_in),
    .frame_in       ({roll_in, pitch_in, yaw_in}),
    .active_out     (active),
    .pend_valid_out (pend_valid),
    .overrun_out    (overrun_out)
  );

  // Next-state, channel select, timeout counter and frame counter.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    tcnt_d      = tcnt_q;
    fcnt_d      = fcnt_q;
    timeout_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (capture) begin
          state_d = LOAD;
          sel_d   = SEL_ROLL;
        end
      end
      LOAD: begin
        tcnt_d = '0;
        if (!configured_in) begin
          state_d = IDLE;
          sel_d   = SEL_ROLL;
        end else begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!configured_in) begin
          state_d = IDLE;
          sel_d   = SEL_ROLL;
        end else begin
          tcnt_d = tcnt_q + TIMEOUT_W'(1);
          if (done_in || tmo_hit) begin
            // done wins over a coincident timeout
            timeout_set = ~done_in;
            if (sel_q == SEL_YAW) begin
              state_d = IDLE;
              sel_d   = SEL_ROLL;
              fcnt_d  = fcnt_q + FCNT_W'(1);
            end else begin
              state_d = LOAD;
              sel_d   = sel_q + 2'd1;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = SEL_ROLL;
      end
    endcase
  end

  // State register plus sticky timeout flag (a new timeout beats clear).
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      sel_q     <= SEL_ROLL;
      tcnt_q    <= '0;
      fcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      tcnt_q  <= tcnt_d;
      fcnt_q  <= fcnt_d;
      if (timeout_set)       timeout_q <= 1'b1;
      else if (clear_err_in) timeout_q <= 1'b0;
    end
  end

  assign write_enable_out  = (state_q == LOAD);
  assign output_select_out = sel_q;
  assign busy_out          = (state_q != IDLE);
  assign timeout_out       = timeout_q;
  assign frame_count_out   = fcnt_q;
  assign roll_out          = active[3*ANG_W-1:2*ANG_W];
  assign pitch_out         = active[2*ANG_W-1:ANG_W];
  assign yaw_out           = active[ANG_W-1:0];

endmodule

// File: doc/mcu_frame_sched.md
Name: mcu_frame_sched

Overview:
Sequencer that feeds Kalman-filter angle frames (roll, pitch, yaw) to the MCU SPI slave interface one channel at a time. It drives write_enable and output_select toward the MCU interface and waits for its done pulse between channels. It holds each accepted frame stable until all three channels have been sent, and buffers one pending frame behind it. It reports overrun, done-timeout and a completed-frame count.

Parameters:
TIMEOUT_CYCLES, 50000, clk cycles to wait for done_in after a write_enable pulse before forcing an advance
TIMEOUT_W, 16, width of timeout counter; must satisfy 2^TIMEOUT_W > TIMEOUT_CYCLES
FCNT_W, 8, width of completed-frame counter

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
angles_valid_in  in  1  one-cycle pulse, new frame on roll_in/pitch_in/yaw_in
roll_in  in  16  roll angle from KF
pitch_in  in  16  pitch angle from KF
yaw_in  in  16  yaw angle from KF
configured_in  in  1  MCU interface register map configured (level)
done_in  in  1  MCU interface finished current channel output (pulse)
clear_err_in  in  1  clears overrun_out and timeout_out
write_enable_out  in/out: out  1  one-cycle load pulse to MCU interface
output_select_out  out  2  00 roll, 01 pitch, 10 yaw; never 11
roll_out, pitch_out, yaw_out  out  16 each  latched active frame to MCU interface
busy_out  out  1  frame in progress (state != IDLE)
overrun_out  out  1  sticky: a buffered frame was overwritten
timeout_out  out  1  sticky: done_in not seen within TIMEOUT_CYCLES
frame_count_out  out  FCNT_W  completed frames, wraps modulo 2^FCNT_W

Behaviour:
- Reset values: all outputs 0. State IDLE. Active and pending frame registers 0. pend_valid 0. Timeout counter 0.
- States: IDLE, LOAD, WAIT_DONE.
- Frame capture:
  - In IDLE with configured_in=1: if pend_valid, copy the pending registers to the active registers and clear pend_valid. Otherwise, if angles_valid_in, copy roll_in/pitch_in/yaw_in to the active registers directly.
  - Either way, set sel=00 and go to LOAD on the next clock.
- angles_valid_in when not starting from it, including busy states and the IDLE cycle that consumes pending: write pending registers and set pend_valid. If pend_valid was already 1 and is not being consumed that cycle, set overrun_out. The newest frame always wins.
- angles_valid_in in IDLE with configured_in=0 is buffered in pending, subject to the same overrun rule.
- LOAD: write_enable_out=1 for exactly this cycle. output_select_out=sel, stable from LOAD through WAIT_DONE. Clear the timeout counter. Next state is WAIT_DONE.
- WAIT_DONE: increment the timeout counter each cycle.
  - On done_in=1, or on counter == TIMEOUT_CYCLES-1 (which also sets timeout_out), advance.
  - If sel=10: go to IDLE, frame_count_out+1, sel=00.
  - Otherwise: sel+1, then LOAD.
  - done_in and timeout in the same cycle count as done; timeout_out is not set.
- done_in outside WAIT_DONE is ignored.
- Latency: angles_valid_in in IDLE leads to the first write_enable_out 1 cycle later. Minimum frame time is 6 cycles plus 3 done latencies. After the last done, a pending frame's write_enable_out comes 2 cycles later (IDLE, then LOAD).
- configured_in falling in LOAD or WAIT_DONE: abort to IDLE next cycle. Discard the active frame, sel=00, no count increment. Pending is kept.
- clear_err_in clears both sticky flags. A set event in the same cycle wins.
- roll_out/pitch_out/yaw_out change only on frame capture in IDLE.

Decomposition:
- Shared package mcu_pkg: state enum (IDLE, LOAD, WAIT_DONE) and select constants SEL_ROLL=2'b00, SEL_PITCH=2'b01, SEL_YAW=2'b10. The same select encoding is used by the MCU interface input mux.
- One natural sub-module: mcu_frame_buf, holding the active and pending 48-bit registers, pend_valid and overrun detection. The FSM, timeout counter and frame counter stay in the top level.

Test Plan:
1. configured_in=1; pulse angles_valid_in with roll=16'h1111, pitch=16'h2222, yaw=16'h3333; return done_in 5 cycles after each write_enable_out. Expect 3 write_enable_out pulses with select 00, 01, 10, outputs holding 1111/2222/3333, frame_count_out=1, busy_out low after the third done.
2. Pulse a second frame (AAAA/BBBB/CCCC) mid-frame 1, then a third (DDDD/EEEE/FFFF) before frame 1 ends. Expect overrun_out=1, the second frame never output, the third frame starting 2 cycles after the last done, frame_count_out=2.
3. TIMEOUT_CYCLES=20; never assert done_in. Expect write_enable_out every 21 cycles with select stepping 00, 01, 10, timeout_out=1, frame_count_out=1. Then clear_err_in: timeout_out=0.
4. Drop configured_in during WAIT_DONE with sel=01. Expect IDLE next cycle, no count increment, no write_enable_out while configured_in=0. Raise configured_in with a pending frame present: that frame starts at sel=00.
5. Assert n_rst low during WAIT_DONE with pend_valid=1. Expect all outputs 0 immediately, pending lost, no write_enable_out after release until a new angles_valid_in.
6. Wrap check: FCNT_W=2, 5 complete frames -> frame_count_out=1.
